// File: rtl/fadd_norm_round_if.sv
// Bundle between the addition/normalization pipeline register and the
// normalization/rounding stage. The master drives the n_* bundle and
// receives the s_* result; the slave is the rounding stage itself.
interface fadd_norm_round_if;
  logic        n_valid;
  logic [1:0]  n_rm;
  logic        n_sign;
  logic [9:0]  n_exp10;
  logic        n_is_nan;
  logic        n_is_inf;
  logic [22:0] n_inf_nan_frac;
  logic [47:0] n_z48;

  logic        s_valid;
  logic [31:0] s_result;
  logic        s_overflow;
  logic        s_inexact;

  modport master (
    output n_valid, n_rm, n_sign, n_exp10, n_is_nan, n_is_inf,
           n_inf_nan_frac, n_z48,
    input  s_valid, s_result, s_overflow, s_inexact
  );

  modport slave (
    input  n_valid, n_rm, n_sign, n_exp10, n_is_nan, n_is_inf,
           n_inf_nan_frac, n_z48,
    output s_valid, s_result, s_overflow, s_inexact
  );
endinterface

// File: rtl/fadd_norm_round.sv
// fadd_norm_round: final stage of the pipelined binary32 adder.
// Normalizes the 48-bit raw sum, rounds it in the requested IEEE-754 mode,
// resolves NaN/Inf/zero/overflow and registers the result with flags.
// Optional build macro FADD_NORM_ACCRUED_FLAGS_EN adds flags_clr input and
// a sticky acc_flags = {overflow, inexact} output.
module fadd_norm_round (
  input  logic             clk,
  input  logic             clrn,
  input  logic             e,
`ifdef FADD_NORM_ACCRUED_FLAGS_EN
  input  logic             flags_clr,
  output logic [1:0]       acc_flags,
`endif
  fadd_norm_round_if.slave bus
);

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RD  = 2'b01,
    RM_RU  = 2'b10,
    RM_RZ  = 2'b11
  } rm_e;

  rm_e         rm;
  logic [46:0] probe;
  logic        found;
  logic [5:0]  lz;
  logic [9:0]  shamt;
  logic [46:0] zs;
  logic        rsticky;
  logic [9:0]  exp_n;
  logic [23:0] sig;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [24:0] sig_sum;
  logic [23:0] sig_r;
  logic [9:0]  exp_r;
  logic        ovf;
  logic [31:0] res_c;
  logic        ovf_c;
  logic        inx_c;

  logic        s_valid_d,    s_valid_q;
  logic [31:0] s_result_d,   s_result_q;
  logic        s_overflow_d, s_overflow_q;
  logic        s_inexact_d,  s_inexact_q;

  assign rm = rm_e'(bus.n_rm);

  // Normalize, round and resolve special cases for the current bundle.
  always_comb begin
    // Leading-zero count of z48[46:0] by walking a left-shifting probe.
    probe = bus.n_z48[46:0];
    found = 1'b0;
    lz    = '0;
    for (int unsigned i = 0; i < 47; i++) begin
      if (!found) begin
        if (probe[46]) begin
          found = 1'b1;
        end else begin
          lz    = lz + 6'd1;
          probe = {probe[45:0], 1'b0};
        end
      end
    end

    shamt   = '0;
    zs      = bus.n_z48[46:0];
    rsticky = 1'b0;
    exp_n   = bus.n_exp10;
    if (bus.n_z48[47]) begin
      zs      = bus.n_z48[47:1];
      rsticky = bus.n_z48[0];
      exp_n   = bus.n_exp10 + 10'd1;
    end else if (bus.n_exp10 != 10'd0) begin
      // Left shift is capped so the exponent never drops below 1.
      shamt = ({4'b0, lz} < (bus.n_exp10 - 10'd1)) ? {4'b0, lz}
                                                    : (bus.n_exp10 - 10'd1);
      zs    = bus.n_z48[46:0] << shamt;
      exp_n = bus.n_exp10 - shamt;
    end

    sig    = zs[46:23];
    guard  = zs[22];
    sticky = (|zs[21:0]) | rsticky;

    case (rm)
      RM_RNE:  inc = guard & (sticky | sig[0]);
      RM_RD:   inc = (guard | sticky) & bus.n_sign;
      RM_RU:   inc = (guard | sticky) & ~bus.n_sign;
      default: inc = 1'b0;
    endcase

    sig_sum = {1'b0, sig} + {24'b0, inc};
    sig_r   = sig_sum[23:0];
    exp_r   = exp_n;
    if (sig_sum[24]) begin
      sig_r = 24'h800000;
      exp_r = exp_n + 10'd1;
    end else if (!sig[23] && sig_sum[23] && (exp_n == 10'd0)) begin
      // A denormal that rounds up into the hidden bit becomes the smallest normal.
      exp_r = 10'd1;
    end

    ovf = (exp_r >= 10'd255);

    res_c = '0;
    ovf_c = 1'b0;
    inx_c = 1'b0;
    if (bus.n_is_nan || bus.n_is_inf) begin
      res_c = {bus.n_sign, 8'hFF, bus.n_inf_nan_frac};
    end else if (bus.n_z48 == 48'd0) begin
      res_c = {bus.n_sign, 31'b0};
    end else if (ovf) begin
      ovf_c = 1'b1;
      inx_c = 1'b1;
      case (rm)
        RM_RNE:  res_c = {bus.n_sign, 31'h7F800000};
        RM_RD:   res_c = bus.n_sign ? 32'hFF800000 : 32'h7F7FFFFF;
        RM_RU:   res_c = bus.n_sign ? 32'hFF7FFFFF : 32'h7F800000;
        default: res_c = {bus.n_sign, 31'h7F7FFFFF};
      endcase
    end else begin
      res_c = {bus.n_sign, (sig_r[23] ? exp_r[7:0] : 8'h00), sig_r[22:0]};
      inx_c = guard | sticky;
    end
  end

  // Output register next-state: load on enable, hold on stall.
  always_comb begin
    s_valid_d    = s_valid_q;
    s_result_d   = s_result_q;
    s_overflow_d = s_overflow_q;
    s_inexact_d  = s_inexact_q;
    if (e) begin
      s_valid_d    = bus.n_valid;
      s_result_d   = res_c;
      s_overflow_d = ovf_c;
      s_inexact_d  = inx_c;
    end
  end

  // Output pipeline register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s_valid_q    <= 1'b0;
      s_result_q   <= '0;
      s_overflow_q <= 1'b0;
      s_inexact_q  <= 1'b0;
    end else begin
      s_valid_q    <= s_valid_d;
      s_result_q   <= s_result_d;
      s_overflow_q <= s_overflow_d;
      s_inexact_q  <= s_inexact_d;
    end
  end

  assign bus.s_valid    = s_valid_q;
  assign bus.s_result   = s_result_q;
  assign bus.s_overflow = s_overflow_q;
  assign bus.s_inexact  = s_inexact_q;

`ifdef FADD_NORM_ACCRUED_FLAGS_EN
  logic [1:0] acc_flags_d, acc_flags_q;

  // Sticky flag accumulation; clear wins over a same-cycle set and ignores e.
  always_comb begin
    acc_flags_d = acc_flags_q;
    if (flags_clr) begin
      acc_flags_d = '0;
    end else if (e && bus.n_valid) begin
      acc_flags_d = acc_flags_q | {ovf_c, inx_c};
    end
  end

  // Accrued flag register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) acc_flags_q <= '0;
    else       acc_flags_q <= acc_flags_d;
  end

  assign acc_flags = acc_flags_q;
`endif

endmodule

// File: tb/tb_fadd_norm_round.sv
// Directed, table-driven bench for fadd_norm_round.
module tb_fadd_norm_round;

  logic clk;
  logic clrn;
  logic e;
`ifdef FADD_NORM_ACCRUED_FLAGS_EN
  logic       flags_clr;
  logic [1:0] acc_flags;
`endif

  fadd_norm_round_if bus ();

  fadd_norm_round dut (
    .clk       (clk),
    .clrn      (clrn),
    .e         (e),
`ifdef FADD_NORM_ACCRUED_FLAGS_EN
    .flags_clr (flags_clr),
    .acc_flags (acc_flags),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rm;
    logic        sign;
    logic [9:0]  exp10;
    logic        nan;
    logic        inf;
    logic [22:0] frac;
    logic [47:0] z;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.n_valid        = valid;
    bus.n_rm           = v.rm;
    bus.n_sign         = v.sign;
    bus.n_exp10        = v.exp10;
    bus.n_is_nan       = v.nan;
    bus.n_is_inf       = v.inf;
    bus.n_inf_nan_frac = v.frac;
    bus.n_z48          = v.z;
  endtask

  function automatic logic [63:0] outs();
    return {29'b0, bus.s_valid, bus.s_result, bus.s_overflow, bus.s_inexact};
  endfunction

  function automatic logic [63:0] want(input vec_t v);
    return {29'b0, 1'b1, v.res, v.ovf, v.inx};
  endfunction

  initial begin
    //           rm     s     exp10   nan   inf   frac        z48                  result        ovf   inx
    vt[0]  = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'h40000000, 1'b0, 1'b0};
    vt[1]  = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h000000800000, 32'h34000000, 1'b0, 1'b0};
    vt[2]  = '{2'd0, 1'b0, 10'd5,   1'b0, 1'b0, 23'h0,      48'h000000800000, 32'h00000010, 1'b0, 1'b0};
    vt[3]  = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000400000, 32'h3F800000, 1'b0, 1'b1};
    vt[4]  = '{2'd2, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000400000, 32'h3F800001, 1'b0, 1'b1};
    vt[5]  = '{2'd1, 1'b1, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000400000, 32'hBF800001, 1'b0, 1'b1};
    vt[6]  = '{2'd0, 1'b0, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'h7F800000, 1'b1, 1'b1};
    vt[7]  = '{2'd3, 1'b0, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'h7F7FFFFF, 1'b1, 1'b1};
    vt[8]  = '{2'd1, 1'b0, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'h7F7FFFFF, 1'b1, 1'b1};
    vt[9]  = '{2'd1, 1'b1, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'hFF800000, 1'b1, 1'b1};
    vt[10] = '{2'd2, 1'b1, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'hFF7FFFFF, 1'b1, 1'b1};
    vt[11] = '{2'd2, 1'b0, 10'd254, 1'b0, 1'b0, 23'h0,      48'h800000000000, 32'h7F800000, 1'b1, 1'b1};
    vt[12] = '{2'd0, 1'b0, 10'd255, 1'b1, 1'b0, 23'h400000, 48'h000000001234, 32'h7FC00000, 1'b0, 1'b0};
    vt[13] = '{2'd0, 1'b1, 10'd255, 1'b0, 1'b1, 23'h0,      48'h000000000000, 32'hFF800000, 1'b0, 1'b0};
    vt[14] = '{2'd0, 1'b0, 10'd255, 1'b1, 1'b1, 23'h000001, 48'h800000000001, 32'h7F800001, 1'b0, 1'b0};
    vt[15] = '{2'd0, 1'b1, 10'd100, 1'b0, 1'b0, 23'h0,      48'h000000000000, 32'h80000000, 1'b0, 1'b0};
    vt[16] = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h7FFFFFC00000, 32'h40000000, 1'b0, 1'b1};
    vt[17] = '{2'd0, 1'b0, 10'd0,   1'b0, 1'b0, 23'h0,      48'h3FFFFFC00000, 32'h00800000, 1'b0, 1'b1};
    vt[18] = '{2'd0, 1'b0, 10'd1,   1'b0, 1'b0, 23'h0,      48'h200000000000, 32'h00400000, 1'b0, 1'b0};
    vt[19] = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h800000000001, 32'h40000000, 1'b0, 1'b1};
    vt[20] = '{2'd2, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h800000000001, 32'h40000001, 1'b0, 1'b1};
    vt[21] = '{2'd0, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000C00000, 32'h3F800002, 1'b0, 1'b1};
    vt[22] = '{2'd3, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000FFFFFF, 32'h3F800001, 1'b0, 1'b1};
    vt[23] = '{2'd1, 1'b0, 10'd127, 1'b0, 1'b0, 23'h0,      48'h400000FFFFFF, 32'h3F800001, 1'b0, 1'b1};

    clrn = 1'b0;
    e    = 1'b0;
`ifdef FADD_NORM_ACCRUED_FLAGS_EN
    flags_clr = 1'b0;
`endif
    drive(vt[0], 1'b0);
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    clrn = 1'b1;
    e    = 1'b1;

    // Table vectors, one bundle per cycle, checked one cycle later.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i], 1'b1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), want(vt[i]));
    end

    // Invalid bundle clears s_valid.
    drive(vt[1], 1'b0);
    @(negedge clk);
    check("invalid_valid", {63'b0, bus.s_valid}, 64'd0);

    // Stall: load vt[0], then hold e=0 for three cycles while inputs change.
    drive(vt[0], 1'b1);
    @(negedge clk);
    check("stall_load", outs(), want(vt[0]));
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(vt[6 + i], (i != 1));
      @(negedge clk);
      check($sformatf("stall_hold%0d", i), outs(), want(vt[0]));
    end

    // Asynchronous reset in the middle of the stall, away from any clock edge.
    #2 clrn = 1'b0;
    #1 check("async_reset_midstall", outs(), 64'd0);
    @(negedge clk);
    check("reset_held_stall", outs(), 64'd0);
    clrn = 1'b1;
    e    = 1'b1;
    drive(vt[4], 1'b1);
    @(negedge clk);
    check("after_reset", outs(), want(vt[4]));

`ifdef FADD_NORM_ACCRUED_FLAGS_EN
    // Start from a clean accumulator.
    flags_clr = 1'b1;
    drive(vt[0], 1'b0);
    @(negedge clk);
    flags_clr = 1'b0;
    check("acc_cleared", {62'b0, acc_flags}, 64'd0);
    // Exact bundle leaves it clear.
    drive(vt[0], 1'b1);
    @(negedge clk);
    check("acc_exact", {62'b0, acc_flags}, 64'd0);
    // Overflow, then inexact-only.
    drive(vt[6], 1'b1);
    @(negedge clk);
    check("acc_ovf", {62'b0, acc_flags}, 64'd3);
    flags_clr = 1'b1;
    drive(vt[0], 1'b0);
    @(negedge clk);
    flags_clr = 1'b0;
    drive(vt[3], 1'b1);
    @(negedge clk);
    check("acc_inx_only", {62'b0, acc_flags}, 64'd1);
    drive(vt[7], 1'b1);
    @(negedge clk);
    check("acc_both", {62'b0, acc_flags}, 64'd3);
    // Clear beats a simultaneous valid bundle, set lands the next cycle.
    flags_clr = 1'b1;
    drive(vt[6], 1'b1);
    @(negedge clk);
    check("acc_clr_priority", {62'b0, acc_flags}, 64'd0);
    flags_clr = 1'b0;
    @(negedge clk);
    check("acc_set_after_clr", {62'b0, acc_flags}, 64'd3);
    // Clear works while stalled; stalled bundle does not set.
    e = 1'b0;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("acc_clr_stalled", {62'b0, acc_flags}, 64'd0);
    @(negedge clk);
    check("acc_no_set_stalled", {62'b0, acc_flags}, 64'd0);
    e = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
